// File: rtl/seg7_snoop_to_asc.sv
// seg7_snoop_to_asc
//   Snoops a multiplexed, active-low 7-segment bus and recovers the character
//   shown on each digit. Each digit value must sit unchanged for STABLE_CYCLES
//   samples before it is accepted. Accepted values are decoded to ASCII and
//   compared with the last character reported for that digit. Only changes
//   are queued as {digit, char} records on a valid/ready stream.
// Ports
//   clk        sole clock
//   rst        synchronous, active-high reset
//   seg_in     segment lines, active-low (bit0 top ... bit6 middle)
//   dig_en_n   digit enables, active-low; a sample is valid with exactly one bit low
//   out_valid  head record available
//   out_ready  consumer accepts the head record
//   out_char   ASCII of the head record (0 when empty)
//   out_digit  digit index of the head record (0 when empty)
//   overflow   sticky: a change was dropped because the FIFO was full
module seg7_snoop_to_asc #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIG_W         = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_en_n,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic [DIG_W-1:0]      out_digit,
  output logic                  overflow
);
  localparam int         PW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0] SC_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] SC_M2  = 8'(STABLE_CYCLES - 2);

  typedef struct packed {
    logic [DIG_W-1:0] dig;
    logic [7:0]       ch;
  } rec_t;

  function automatic logic [7:0] seg2asc(input logic [6:0] s);
    case (s)
      7'b1000000: seg2asc = "0";  7'b1111001: seg2asc = "1";
      7'b0100100: seg2asc = "2";  7'b0110000: seg2asc = "3";
      7'b0011001: seg2asc = "4";  7'b0010010: seg2asc = "5";
      7'b0000010: seg2asc = "6";  7'b1111000: seg2asc = "7";
      7'b0000000: seg2asc = "8";  7'b0011000: seg2asc = "9";
      7'b0001000: seg2asc = "A";  7'b0000011: seg2asc = "B";
      7'b1000110: seg2asc = "C";  7'b0100001: seg2asc = "D";
      7'b0000110: seg2asc = "E";  7'b0001110: seg2asc = "F";
      7'b0010000: seg2asc = "G";  7'b0001011: seg2asc = "H";
      7'b1111011: seg2asc = "I";  7'b1100001: seg2asc = "J";
      7'b0000111: seg2asc = "K";  7'b1000111: seg2asc = "L";
      7'b0101011: seg2asc = "N";  7'b0100011: seg2asc = "O";
      7'b0001100: seg2asc = "P";  7'b0101111: seg2asc = "R";
      7'b1001110: seg2asc = "T";  7'b1000001: seg2asc = "U";
      7'b0001001: seg2asc = "X";  7'b1111111: seg2asc = " ";
      7'b0111111: seg2asc = "-";
      default:    seg2asc = "?";
    endcase
  endfunction

  // two-flop input synchroniser; reset loads blanking
  logic [6:0]            seg1_q, seg2_q;
  logic [NUM_DIGITS-1:0] en1_q, en2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg1_q <= '1; seg2_q <= '1;
      en1_q  <= '1; en2_q  <= '1;
    end else begin
      seg1_q <= seg_in;   seg2_q <= seg1_q;
      en1_q  <= dig_en_n; en2_q  <= en1_q;
    end
  end

  // one-low detect and index of the low bit
  logic [3:0]       nlow;
  logic [DIG_W-1:0] idx;
  logic             samp_vld;

  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!en2_q[i]) begin
        nlow = nlow + 4'd1;
        idx  = DIG_W'(i);
      end
    end
  end
  assign samp_vld = (nlow == 4'd1);

  // stability counter against the previous cycle's sample
  logic             prev_vld_q;
  logic [DIG_W-1:0] prev_idx_q;
  logic [6:0]       prev_seg_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             same, accept;

  assign same   = samp_vld && prev_vld_q && (idx == prev_idx_q) && (seg2_q == prev_seg_q);
  assign cnt_d  = !same ? 8'd0 : (cnt_q == SC_MAX) ? cnt_q : cnt_q + 8'd1;
  // fires only on the step into STABLE_CYCLES-1; saturation keeps it from repeating
  assign accept = same && (cnt_q == SC_M2);

  // vld_pipe_q[0]: accepted sample held; vld_pipe_q[1]: decoded char held
  logic [1:0]       vld_pipe_q;
  logic [DIG_W-1:0] acc_idx_q, dec_idx_q;
  logic [6:0]       acc_seg_q;
  logic [7:0]       dec_char_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld_q <= 1'b0;
      prev_idx_q <= '0;
      prev_seg_q <= '1;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      acc_idx_q  <= '0;
      acc_seg_q  <= '1;
      dec_idx_q  <= '0;
      dec_char_q <= '0;
    end else begin
      prev_vld_q <= samp_vld;
      prev_idx_q <= idx;
      prev_seg_q <= seg2_q;
      cnt_q      <= cnt_d;
      vld_pipe_q <= {vld_pipe_q[0], accept};
      if (accept) begin
        acc_idx_q <= idx;
        acc_seg_q <= seg2_q;
      end
      dec_idx_q  <= acc_idx_q;
      dec_char_q <= seg2asc(acc_seg_q);
    end
  end

  // shadow compare and record FIFO
  logic [NUM_DIGITS-1:0][7:0] shadow_q;
  rec_t                       mem_q [FIFO_DEPTH];
  logic [PW:0]                wr_q, rd_q;
  logic                       full, empty, differ, push, pop, overflow_q;

  assign empty  = (wr_q == rd_q);
  // full is taken before any same-cycle pop
  assign full   = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign differ = vld_pipe_q[1] && (dec_char_q != shadow_q[dec_idx_q]);
  assign push   = differ && !full;
  assign pop    = !empty && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      shadow_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_q                <= wr_q + 1'b1;
        shadow_q[dec_idx_q] <= dec_char_q;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (differ && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= '{dig: dec_idx_q, ch: dec_char_q};
  end

  assign out_valid = !empty;
  assign out_char  = empty ? 8'h00 : mem_q[rd_q[PW-1:0]].ch;
  assign out_digit = empty ? '0    : mem_q[rd_q[PW-1:0]].dig;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_snoop_to_asc.sv
module tb_seg7_snoop_to_asc;
  localparam int ND = 4, DW = 2, SC = 16, FD = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic [6:0]    seg_in = '1;
  logic [ND-1:0] dig_en_n = '1;
  logic          out_ready = 1'b0;
  logic          out_valid, overflow;
  logic [7:0]    out_char;
  logic [DW-1:0] out_digit;

  seg7_snoop_to_asc #(.NUM_DIGITS(ND), .DIG_W(DW), .STABLE_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en_n(dig_en_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_digit(out_digit), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // glyph table {pattern bit6..0, ascii}
  logic [14:0] tbl [31] = '{
    {7'b1000000, 8'h30}, {7'b1111001, 8'h31}, {7'b0100100, 8'h32}, {7'b0110000, 8'h33},
    {7'b0011001, 8'h34}, {7'b0010010, 8'h35}, {7'b0000010, 8'h36}, {7'b1111000, 8'h37},
    {7'b0000000, 8'h38}, {7'b0011000, 8'h39}, {7'b0001000, 8'h41}, {7'b0000011, 8'h42},
    {7'b1000110, 8'h43}, {7'b0100001, 8'h44}, {7'b0000110, 8'h45}, {7'b0001110, 8'h46},
    {7'b0010000, 8'h47}, {7'b0001011, 8'h48}, {7'b1111011, 8'h49}, {7'b1100001, 8'h4A},
    {7'b0000111, 8'h4B}, {7'b1000111, 8'h4C}, {7'b0101011, 8'h4E}, {7'b0100011, 8'h4F},
    {7'b0001100, 8'h50}, {7'b0101111, 8'h52}, {7'b1001110, 8'h54}, {7'b1000001, 8'h55},
    {7'b0001001, 8'h58}, {7'b1111111, 8'h20}, {7'b0111111, 8'h2D}
  };

  function automatic logic [7:0] ref_dec(input logic [6:0] s);
    for (int i = 0; i < 31; i++) if (tbl[i][14:8] == s) return tbl[i][7:0];
    return 8'h3F;
  endfunction

  // reference model: runs of identical pin samples, pending decisions, record queue
  typedef struct { int due; int idx; logic [7:0] ch; } pend_t;
  typedef struct { int idx; logic [7:0] ch; } rec_t;
  pend_t      pend[$];
  rec_t       mq[$];
  logic [7:0] shadow [ND];
  logic       m_ovf;
  int         edge_n = 0, run = 0, prev_idx = 0;
  logic       prev_vld = 1'b0;
  logic [6:0] prev_seg = '1;
  int         got[$];   // records popped from the DUT, digit*256+char

  task automatic model_clear();
    pend.delete(); mq.delete();
    for (int i = 0; i < ND; i++) shadow[i] = 8'h00;
    m_ovf = 1'b0; run = 0; prev_vld = 1'b0;
  endtask

  task automatic model_edge();
    int    nl, ix;
    logic  v, full;
    pend_t p;
    edge_n++;
    if (rst) begin model_clear(); return; end
    full = (mq.size() == FD);
    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    while (pend.size() > 0 && pend[0].due == edge_n) begin
      p = pend.pop_front();
      if (p.ch != shadow[p.idx]) begin
        if (!full) begin mq.push_back('{p.idx, p.ch}); shadow[p.idx] = p.ch; end
        else m_ovf = 1'b1;
      end
    end
    nl = 0; ix = 0;
    for (int i = 0; i < ND; i++) if (!dig_en_n[i]) begin nl++; ix = i; end
    v = (nl == 1);
    if (v && prev_vld && ix == prev_idx && seg_in == prev_seg) begin
      if (run <= SC) run++;
    end else run = v ? 1 : 0;
    prev_vld = v; prev_idx = ix; prev_seg = seg_in;
    // the SC-th identical pin sample is pushed four edges later
    if (run == SC) pend.push_back('{edge_n + 4, ix, ref_dec(seg_in)});
  endtask

  task automatic step(input logic [ND-1:0] en, input logic [6:0] s, input logic rdy, input logic r);
    dig_en_n = en; seg_in = s; out_ready = rdy; rst = r;
    if (out_valid === 1'b1 && rdy && !r) got.push_back(int'(out_digit) * 256 + int'(out_char));
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("char", out_char, mq[0].ch);
      chk("digit", out_digit, mq[0].idx);
    end
    chk("ovf", overflow, m_ovf);
  endtask

  task automatic hold(input logic [ND-1:0] en, input logic [6:0] s, input logic rdy, input int n);
    for (int k = 0; k < n; k++) step(en, s, rdy, 1'b0);
  endtask

  initial begin
    int lat;
    logic [ND-1:0] en;
    logic [6:0] s;
    logic rdy_mode;
    int len;
    model_clear();

    // reset state
    for (int k = 0; k < 3; k++) step('1, '1, 1'b1, 1'b1);
    chk("rst_valid", out_valid, 0);
    chk("rst_char", out_char, 0);
    chk("rst_digit", out_digit, 0);
    chk("rst_ovf", overflow, 0);
    hold('1, '1, 1'b1, 2);

    // single stable digit; latency counted in steps (step k carries edge k-1 after the change)
    got.delete(); lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step(4'b1011, 7'b0011001, 1'b1, 1'b0);
      if (lat < 0 && out_valid) lat = k;
    end
    chk("t1_latency", lat, SC + 4);
    chk("t1_count", got.size(), 1);
    if (got.size() > 0) chk("t1_rec", got[0], 2*256 + 8'h34);

    // blank interruption of the same value, then a real change
    got.delete();
    hold(4'b1111, 7'b0011001, 1'b1, 5);
    hold(4'b1011, 7'b0011001, 1'b1, 40);
    chk("t2_none", got.size(), 0);
    hold(4'b1011, 7'b0001000, 1'b1, 40);
    chk("t2_count", got.size(), 1);
    if (got.size() > 0) chk("t2_rec", got[0], 2*256 + 8'h41);

    // glitch shorter than the stability window, then multi-low enables
    got.delete();
    hold(4'b1011, 7'b0001001, 1'b1, SC - 2);
    hold(4'b1011, 7'b0001000, 1'b1, 30);
    hold(4'b0011, 7'b0000000, 1'b1, 40);
    chk("t3_none", got.size(), 0);

    // scan four digits
    got.delete();
    hold(4'b1110, 7'b0000000, 1'b1, 20);
    hold(4'b1101, 7'b0111111, 1'b1, 20);
    hold(4'b1011, 7'b1111111, 1'b1, 20);
    hold(4'b0111, 7'b1010101, 1'b1, 20);
    hold(4'b1111, 7'b1111111, 1'b1, 8);
    chk("t4_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t4_r0", got[0], 0*256 + 8'h38);
      chk("t4_r1", got[1], 1*256 + 8'h2D);
      chk("t4_r2", got[2], 2*256 + 8'h20);
      chk("t4_r3", got[3], 3*256 + 8'h3F);
    end

    // backpressure: FD+1 changes with out_ready low
    got.delete();
    hold(4'b1110, 7'b1111001, 1'b0, 20);
    hold(4'b1101, 7'b0100100, 1'b0, 20);
    hold(4'b1011, 7'b0110000, 1'b0, 20);
    hold(4'b0111, 7'b0010010, 1'b0, 20);
    hold(4'b1110, 7'b0000010, 1'b0, 20);
    hold(4'b1111, 7'b1111111, 1'b0, 6);
    chk("t5_ovf", overflow, 1);
    chk("t5_head", int'(out_digit) * 256 + int'(out_char), 0*256 + 8'h31);
    hold(4'b1111, 7'b1111111, 1'b1, 10);
    chk("t5_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t5_r0", got[0], 0*256 + 8'h31);
      chk("t5_r3", got[3], 3*256 + 8'h35);
    end
    got.delete();
    hold(4'b1110, 7'b0000010, 1'b1, 24);
    chk("t5_late", got.size(), 1);
    if (got.size() > 0) chk("t5_late_rec", got[0], 0*256 + 8'h36);

    // reset with three records queued
    hold(4'b1101, 7'b1111000, 1'b0, 20);
    hold(4'b1011, 7'b0011000, 1'b0, 20);
    hold(4'b0111, 7'b1000110, 1'b0, 20);
    hold(4'b1111, 7'b1111111, 1'b0, 6);
    step(4'b1111, 7'b1111111, 1'b0, 1'b1);
    chk("t6_valid", out_valid, 0);
    chk("t6_ovf", overflow, 0);
    got.delete();
    hold(4'b1110, 7'b0000010, 1'b1, 24);
    hold(4'b0111, 7'b1000110, 1'b1, 24);
    chk("t6_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t6_r0", got[0], 0*256 + 8'h36);
      chk("t6_r1", got[1], 3*256 + 8'h43);
    end

    // randomized segments against the model
    repeat (220) begin
      case ($urandom_range(0, 9))
        0: en = '1;
        1: en = ND'($urandom);
        default: begin en = '1; en[$urandom_range(0, ND-1)] = 1'b0; end
      endcase
      s = ($urandom_range(0, 3) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 30)][14:8];
      len = $urandom_range(1, 2*SC + 4);
      rdy_mode = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) step(en, s, 1'b0, 1'b1);
      for (int k = 0; k < len; k++)
        step(en, s, rdy_mode && ($urandom_range(0, 4) != 0), 1'b0);
    end
    hold('1, '1, 1'b1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
